// File: rtl/async_fifo_top.sv
// async_fifo_top: single-clock FIFO with gray pointers, two-flop pointer synchronisers and registered full/empty flags
module async_fifo_top #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  write_full,
   output logic                  read_empty
);
   localparam int A = ADDR_WIDTH;
   logic [A:0] wbin_q, wbin_d, rbin_q, rbin_d, wptr_q, wptr_d, rptr_q, rptr_d;
   logic [A:0] rq1_wptr_q, rq2_wptr_q, wq1_rptr_q, wq2_rptr_q;
   logic full_q, full_d, empty_q, empty_d, push, pop;
   logic [DATA_WIDTH-1:0] mem_q [0:(1<<A)-1];
   always_comb begin
      push    = write_enable && !full_q;
      pop     = read_enable && !empty_q;
      wbin_d  = wbin_q + {{A{1'b0}}, push};
      rbin_d  = rbin_q + {{A{1'b0}}, pop};
      wptr_d  = wbin_d ^ (wbin_d >> 1);
      rptr_d  = rbin_d ^ (rbin_d >> 1);
      empty_d = rptr_d == rq2_wptr_q;
      full_d  = wptr_d == {~wq2_rptr_q[A:A-1], wq2_rptr_q[A-2:0]};
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wbin_q     <= '0;
         rbin_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         rq1_wptr_q <= '0;
         rq2_wptr_q <= '0;
         wq1_rptr_q <= '0;
         wq2_rptr_q <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else begin
         wbin_q     <= wbin_d;
         rbin_q     <= rbin_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         rq1_wptr_q <= wptr_q;
         rq2_wptr_q <= rq1_wptr_q;
         wq1_rptr_q <= rptr_q;
         wq2_rptr_q <= wq1_rptr_q;
         full_q     <= full_d;
         empty_q    <= empty_d;
      end
   end
   // storage is deliberately left out of reset
   always_ff @(posedge clock) begin
      if (push && !reset) mem_q[wbin_q[A-1:0]] <= write_data;
   end
   assign read_data  = mem_q[rbin_q[A-1:0]];
   assign write_full = full_q;
   assign read_empty = empty_q;
endmodule

// File: tb/tb_async_fifo_top.sv
// tb_async_fifo_top: scoreboard bench for async_fifo_top (depth 8, 8-bit data)
module tb_async_fifo_top;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] write_data = '0;
   logic       write_enable = 1'b0;
   logic       read_enable = 1'b0;
   logic [7:0] read_data;
   logic       write_full, read_empty;
   int         tests = 0, fails = 0, popped = 0;
   logic [7:0] q [$];

   async_fifo_top #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clock(clock), .reset(reset), .write_data(write_data), .write_enable(write_enable),
      .read_enable(read_enable), .read_data(read_data), .write_full(write_full), .read_empty(read_empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drives one cycle; pops are scored before the edge, pushes queued when accepted
   task automatic step(input logic we, input logic [7:0] wd, input logic re);
      write_enable = we;
      write_data   = wd;
      read_enable  = re;
      if (re && !read_empty && !reset) begin
         if (q.size() == 0) check("pop_unexpected", 32'(read_data), 32'hdead);
         else check("pop_data", 32'(read_data), 32'(q.pop_front()));
         popped++;
      end
      if (we && !write_full && !reset) q.push_back(wd);
      @(posedge clock);
      #1;
      write_enable = 1'b0;
      read_enable  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain(input int bound);
      int c = 0;
      while (q.size() > 0 && c < bound) begin
         step(1'b0, 8'h00, 1'b1);
         c++;
      end
      check("drain_left", 32'(q.size()), 32'd0);
   endtask

   initial begin
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_empty", 32'(read_empty), 32'd1);
      check("rst_full", 32'(write_full), 32'd0);
      step(1'b0, 8'h00, 1'b1);
      check("rst_pop_ignored", 32'(read_empty), 32'd1);

      step(1'b1, 8'hA5, 1'b0);
      check("push_k0", 32'(read_empty), 32'd1);
      idle(1);
      check("push_k1", 32'(read_empty), 32'd1);
      idle(1);
      check("push_k2", 32'(read_empty), 32'd1);
      idle(1);
      check("push_k3", 32'(read_empty), 32'd0);
      check("push_data", 32'(read_data), 32'hA5);
      step(1'b0, 8'h00, 1'b1);
      check("pop_empty", 32'(read_empty), 32'd1);

      for (int i = 0; i < 11; i++) begin
         step(1'b1, 8'(i), 1'b0);
         if (i == 6) check("ovf_full7", 32'(write_full), 32'd0);
         if (i == 7) check("ovf_full8", 32'(write_full), 32'd1);
      end
      check("ovf_queued", 32'(q.size()), 32'd8);
      idle(3);
      popped = 0;
      drain(20);
      check("ovf_drained", 32'(popped), 32'd8);
      check("ovf_empty", 32'(read_empty), 32'd1);

      idle(4);
      for (int i = 0; i < 11; i++) begin
         step(1'b0, 8'h00, 1'b1);
         check("udf_empty", 32'(read_empty), 32'd1);
      end
      step(1'b1, 8'h3C, 1'b0);
      idle(3);
      check("udf_ready", 32'(read_empty), 32'd0);
      check("udf_head", 32'(read_data), 32'h3C);
      drain(10);

      popped = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 8'h10 + 8'(i), !read_empty);
      idle(3);
      drain(30);
      check("stream_count", 32'(popped), 32'd20);
      check("stream_empty", 32'(read_empty), 32'd1);

      idle(4);
      for (int i = 0; i < 8; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
      check("fill_full", 32'(write_full), 32'd1);
      idle(3);
      step(1'b0, 8'h00, 1'b1);
      check("rel_k0", 32'(write_full), 32'd1);
      idle(1);
      check("rel_k1", 32'(write_full), 32'd1);
      idle(1);
      check("rel_k2", 32'(write_full), 32'd1);
      idle(1);
      check("rel_k3", 32'(write_full), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
      check("pre_rst_count", 32'(q.size()), 32'd3);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      q.delete();
      check("mid_rst_empty", 32'(read_empty), 32'd1);
      check("mid_rst_full", 32'(write_full), 32'd0);
      step(1'b1, 8'h55, 1'b0);
      idle(3);
      check("post_rst_ready", 32'(read_empty), 32'd0);
      check("post_rst_head", 32'(read_data), 32'h55);
      drain(10);
      check("post_rst_empty", 32'(read_empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
